tdm_demux1_to_4: RTL and testbench
==================================

// Module: tdm_demux1_to_4
// PURPOSE
//   Receive-side partner of the 4-to-1 multiplexer. It takes a time-division-multiplexed
//   stream (slot 0,1,2,3 repeating, one slot per valid beat) and rebuilds four parallel
//   channels i0..i3. Adds frame alignment (sync marker on slot 0) and error recovery.
//   Sits between a TDM link driven by a rotating-select 4:1 mux and the per-channel logic.
// PARAMETERS
//   WIDTH  1  data bits per slot (1 = the bit-wide mux case)
// PORTS
//   clock        input   1      rising-edge clock; the block's only clock
//   reset_n      input   1      asynchronous, active-low reset
//   din          input   WIDTH  TDM data for the current slot
//   din_valid    input   1      din and frame_sync are valid this cycle (one beat)
//   frame_sync   input   1      with din_valid: this beat is slot 0
//   out0..out3   output  WIDTH  last complete frame; outK = slot-K data (i0..i3)
//   frame_valid  output  1      1-cycle pulse: out0..out3 were just updated
//   sync_err     output  1      1-cycle pulse: alignment violation detected
//   locked       output  1      1 while state == LOCKED
//   slot         output  2      next expected slot {s1,s0}; 0 while HUNT
// BEHAVIOUR
//   Reset (async assert, sync release): state HUNT, slot=0, shadow regs=0,
//     out0..out3=0, frame_valid=0, sync_err=0, locked=0.
//   All state changes happen on rising clock only, and only on cycles with din_valid=1.
//   din_valid=0: full hold. Gaps of any length are legal, mid-frame included.
//   FSM states: HUNT, LOCKED.
//   HUNT:
//     - valid & !frame_sync -> beat dropped; no error pulse.
//     - valid & frame_sync -> shadow0<=din; slot<=1; go LOCKED.
//   LOCKED, valid beat, slot = S:
//     - frame_sync & S==0 -> normal slot-0 capture; slot<=1.
//     - !frame_sync & S in 1..2 -> shadowS<=din; slot<=S+1.
//     - !frame_sync & S==3 -> publish: out0..2<=shadow0..2; out3<=din (same edge);
//       frame_valid<=1 for the next cycle; slot<=0 (wrap).
//     - frame_sync & S!=0 (early sync) -> sync_err pulse; partial frame discarded
//       (no publish); beat taken as slot 0: shadow0<=din; slot<=1; stay LOCKED.
//     - !frame_sync & S==0 (missing sync) -> sync_err pulse; beat dropped; slot<=0;
//       go HUNT.
//   Latency: out0..out3 and frame_valid change on the edge that samples the slot-3 beat,
//     i.e. they are visible the cycle after that beat.
//   Outputs hold their last published frame until the next publish. frame_valid and
//     sync_err are never asserted in the same cycle.
//   Shadow regs are not cleared on error. Stale shadow data never reaches the outputs,
//     because a publish requires slots 0..3 in order after a sync.
//   Back-to-back frames (slot 3 then sync on the next cycle) run at full rate:
//     one frame every 4 valid beats.
//   Reset mid-frame: partial frame lost; outputs return to 0 immediately (async).
//   slot is a 2-bit counter and wraps modulo 4 only through the S==3 publish path.
// TESTING
//   1 WIDTH=1, beats 1(sync),0,1,0 back-to-back -> out0..3=1,0,1,0; one frame_valid pulse;
//     locked=1; slot=0.
//   2 Same frame with din_valid=0 gaps of 0..3 cycles between beats -> identical outputs;
//     frame_valid still pulses once, the cycle after the slot-3 beat.
//   3 Before any sync: beats 1,1,1, then sync frame 0,1,1,0 -> first three dropped;
//     out0..3=0,1,1,0; sync_err never pulses.
//   4 Locked; sync at slot 2 -> sync_err pulse; no frame_valid; the new frame
//     0,0,1,1 publishes normally.
//   5 Locked; slot-0 beat without sync -> sync_err pulse; locked=0; outputs hold the
//     previous frame; relock on the next sync.
//   6 reset_n pulsed low mid-frame (slot=2) -> all outputs 0 at once; after release,
//     a full frame publishes correctly. Also run WIDTH=8, 100 random frames vs a
//     reference model.

Source files
------------

// File: rtl/tdm_demux1_to_4.sv
// TDM 1-to-4 demultiplexer: rebuilds four parallel channels from a slot-rotating stream,
// aligning on a slot-0 sync marker and dropping back to HUNT on a missing sync.
module tdm_demux1_to_4 #(
  parameter int WIDTH = 1
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] din,
  input  logic             din_valid,
  input  logic             frame_sync,
  output logic [WIDTH-1:0] out0,
  output logic [WIDTH-1:0] out1,
  output logic [WIDTH-1:0] out2,
  output logic [WIDTH-1:0] out3,
  output logic             frame_valid,
  output logic             sync_err,
  output logic             locked,
  output logic [1:0]       slot
);

  typedef enum logic {HUNT, LOCKED} state_t;

  state_t           state, state_d;
  logic [1:0]       slot_d;
  logic [WIDTH-1:0] sh0, sh1, sh2;
  logic [WIDTH-1:0] sh0_d, sh1_d, sh2_d;
  logic [WIDTH-1:0] out0_d, out1_d, out2_d, out3_d;
  logic             frame_valid_d, sync_err_d;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state       <= HUNT;
      slot        <= 2'd0;
      sh0         <= '0;
      sh1         <= '0;
      sh2         <= '0;
      out0        <= '0;
      out1        <= '0;
      out2        <= '0;
      out3        <= '0;
      frame_valid <= 1'b0;
      sync_err    <= 1'b0;
    end else begin
      state       <= state_d;
      slot        <= slot_d;
      sh0         <= sh0_d;
      sh1         <= sh1_d;
      sh2         <= sh2_d;
      out0        <= out0_d;
      out1        <= out1_d;
      out2        <= out2_d;
      out3        <= out3_d;
      frame_valid <= frame_valid_d;
      sync_err    <= sync_err_d;
    end
  end

  // Pulses default low so they last exactly one cycle; a din_valid=0 cycle holds everything else.
  always_comb begin
    state_d       = state;
    slot_d        = slot;
    sh0_d         = sh0;
    sh1_d         = sh1;
    sh2_d         = sh2;
    out0_d        = out0;
    out1_d        = out1;
    out2_d        = out2;
    out3_d        = out3;
    frame_valid_d = 1'b0;
    sync_err_d    = 1'b0;
    if (din_valid) begin
      case (state)
        HUNT: begin
          if (frame_sync) begin
            sh0_d   = din;
            slot_d  = 2'd1;
            state_d = LOCKED;
          end
        end
        LOCKED: begin
          if (frame_sync) begin
            // An early sync abandons the partial frame and restarts at slot 0.
            sync_err_d = (slot != 2'd0);
            sh0_d      = din;
            slot_d     = 2'd1;
          end else begin
            case (slot)
              2'd0: begin
                sync_err_d = 1'b1;
                slot_d     = 2'd0;
                state_d    = HUNT;
              end
              2'd1: begin
                sh1_d  = din;
                slot_d = 2'd2;
              end
              2'd2: begin
                sh2_d  = din;
                slot_d = 2'd3;
              end
              default: begin
                out0_d        = sh0;
                out1_d        = sh1;
                out2_d        = sh2;
                out3_d        = din;
                frame_valid_d = 1'b1;
                slot_d        = 2'd0;
              end
            endcase
          end
        end
        default: state_d = HUNT;
      endcase
    end
  end

  assign locked = (state == LOCKED);

endmodule

// File: tb/tb_tdm_demux1_to_4.sv
// Bench for tdm_demux1_to_4: a WIDTH=1 and a WIDTH=8 instance share one stream and are
// compared every cycle against a frame-queue model; directed scenarios pin the model.
module tb_tdm_demux1_to_4;

  logic       clock = 1'b0;
  logic       reset_n;
  logic [7:0] din8;
  logic       din_valid;
  logic       frame_sync;

  logic [7:0] d8_o0, d8_o1, d8_o2, d8_o3;
  logic       d8_fv, d8_err, d8_lk;
  logic [1:0] d8_slot;
  logic       d1_o0, d1_o1, d1_o2, d1_o3;
  logic       d1_fv, d1_err, d1_lk;
  logic [1:0] d1_slot;

  int total = 0;
  int bad   = 0;
  int fv_cnt = 0;
  int err_cnt = 0;
  bit chk_on = 1'b0;

  always #5 clock = ~clock;

  tdm_demux1_to_4 #(.WIDTH(8)) dut8 (
    .clock(clock), .reset_n(reset_n), .din(din8), .din_valid(din_valid),
    .frame_sync(frame_sync), .out0(d8_o0), .out1(d8_o1), .out2(d8_o2), .out3(d8_o3),
    .frame_valid(d8_fv), .sync_err(d8_err), .locked(d8_lk), .slot(d8_slot)
  );

  tdm_demux1_to_4 #(.WIDTH(1)) dut1 (
    .clock(clock), .reset_n(reset_n), .din(din8[0]), .din_valid(din_valid),
    .frame_sync(frame_sync), .out0(d1_o0), .out1(d1_o1), .out2(d1_o2), .out3(d1_o3),
    .frame_valid(d1_fv), .sync_err(d1_err), .locked(d1_lk), .slot(d1_slot)
  );

  // Model: a queue of beats received since the last sync; a frame is published when it holds four.
  logic [7:0] fq[$];
  bit         m_locked = 1'b0;
  logic [7:0] exp_out[4] = '{8'd0, 8'd0, 8'd0, 8'd0};
  bit         exp_fv = 1'b0;
  bit         exp_err = 1'b0;

  always @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      fq.delete();
      m_locked = 1'b0;
      for (int k = 0; k < 4; k++) exp_out[k] = 8'd0;
      exp_fv  = 1'b0;
      exp_err = 1'b0;
    end else begin
      exp_fv  = 1'b0;
      exp_err = 1'b0;
      if (din_valid) begin
        if (frame_sync) begin
          if (m_locked && fq.size() != 0) exp_err = 1'b1;
          fq.delete();
          fq.push_back(din8);
          m_locked = 1'b1;
        end else if (m_locked) begin
          if (fq.size() == 0) begin
            exp_err  = 1'b1;
            m_locked = 1'b0;
          end else begin
            fq.push_back(din8);
            if (fq.size() == 4) begin
              for (int k = 0; k < 4; k++) exp_out[k] = fq[k];
              exp_fv = 1'b1;
              fq.delete();
            end
          end
        end
      end
    end
  end

  function automatic logic [1:0] exp_slot();
    return m_locked ? 2'(fq.size()) : 2'd0;
  endfunction

  task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%h want=%h t=%0t", nm, act, exp, $time);
    end
  endtask

  always @(negedge clock) begin
    if (chk_on) begin
      chk("w8_out0", d8_o0, exp_out[0]);
      chk("w8_out1", d8_o1, exp_out[1]);
      chk("w8_out2", d8_o2, exp_out[2]);
      chk("w8_out3", d8_o3, exp_out[3]);
      chk("w8_fv", {7'd0, d8_fv}, {7'd0, exp_fv});
      chk("w8_err", {7'd0, d8_err}, {7'd0, exp_err});
      chk("w8_locked", {7'd0, d8_lk}, {7'd0, m_locked});
      chk("w8_slot", {6'd0, d8_slot}, {6'd0, exp_slot()});
      chk("w1_outs", {4'd0, d1_o3, d1_o2, d1_o1, d1_o0},
          {4'd0, exp_out[3][0], exp_out[2][0], exp_out[1][0], exp_out[0][0]});
      chk("w1_ctl", {3'd0, d1_fv, d1_err, d1_lk, d1_slot},
          {3'd0, exp_fv, exp_err, m_locked, exp_slot()});
      if (d8_fv) fv_cnt++;
      if (d8_err) err_cnt++;
    end
  end

  task automatic beat(input logic [7:0] d, input logic s);
    din8       = d;
    frame_sync = s;
    din_valid  = 1'b1;
    @(posedge clock);
    #1;
    din_valid  = 1'b0;
    frame_sync = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  // Literal check of both DUT and model outputs against a hand-computed frame.
  task automatic lit_frame(input string nm, input logic [3:0] b);
    chk({nm, "_dut"}, {4'd0, d8_o3[0], d8_o2[0], d8_o1[0], d8_o0[0]}, {4'd0, b[3], b[2], b[1], b[0]});
    chk({nm, "_w1"}, {4'd0, d1_o3, d1_o2, d1_o1, d1_o0}, {4'd0, b[3], b[2], b[1], b[0]});
    chk({nm, "_model"}, {4'd0, exp_out[3][0], exp_out[2][0], exp_out[1][0], exp_out[0][0]},
        {4'd0, b[3], b[2], b[1], b[0]});
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int f0, e0;
    logic [7:0] d;
    logic s;
    reset_n    = 1'b0;
    din8       = 8'd0;
    din_valid  = 1'b0;
    frame_sync = 1'b0;
    repeat (2) @(posedge clock);
    chk_on = 1'b1;
    idle(2);
    chk("rst_outs", d8_o0 | d8_o1 | d8_o2 | d8_o3, 8'd0);
    chk("rst_ctl", {4'd0, d8_fv, d8_err, d8_lk, 1'b0}, 8'd0);
    reset_n = 1'b1;
    idle(1);

    // Beats before any sync are dropped silently.
    e0 = err_cnt;
    beat(8'd1, 1'b0); beat(8'd1, 1'b0); beat(8'd1, 1'b0);
    chk("hunt_lock", {7'd0, d8_lk}, 8'd0);
    beat(8'd0, 1'b1); beat(8'd1, 1'b0); beat(8'd1, 1'b0); beat(8'd0, 1'b0);
    lit_frame("hunt_frame", 4'b0110);
    idle(2);
    chk("hunt_noerr", 8'(err_cnt - e0), 8'd0);

    // Back-to-back frame 1,0,1,0.
    f0 = fv_cnt;
    beat(8'd1, 1'b1); beat(8'd0, 1'b0); beat(8'd1, 1'b0); beat(8'd0, 1'b0);
    chk("b2b_fv_now", {7'd0, d8_fv}, 8'd1);
    lit_frame("b2b_frame", 4'b0101);
    chk("b2b_lock_slot", {5'd0, d8_lk, d8_slot}, 8'b100);
    idle(1);
    chk("b2b_fv_once", 8'(fv_cnt - f0), 8'd1);

    // Same frame with gaps of 0..3 idle cycles between beats.
    for (int g = 0; g < 4; g++) begin
      f0 = fv_cnt;
      beat(8'd1, 1'b1); idle(g); beat(8'd0, 1'b0); idle(g);
      beat(8'd1, 1'b0); idle(g); beat(8'd0, 1'b0);
      chk("gap_fv_now", {7'd0, d8_fv}, 8'd1);
      lit_frame("gap_frame", 4'b0101);
      idle(3);
      chk("gap_fv_once", 8'(fv_cnt - f0), 8'd1);
    end

    // Early sync at slot 2, then new frame 0,0,1,1 continues from that beat.
    f0 = fv_cnt;
    beat(8'd1, 1'b1); beat(8'd1, 1'b0);
    beat(8'd0, 1'b1);
    chk("early_err", {7'd0, d8_err}, 8'd1);
    chk("early_nofv", 8'(fv_cnt - f0), 8'd0);
    beat(8'd0, 1'b0); beat(8'd1, 1'b0); beat(8'd1, 1'b0);
    lit_frame("early_frame", 4'b1100);

    // Missing sync at slot 0 drops to HUNT with outputs held.
    beat(8'd1, 1'b0);
    chk("miss_err", {7'd0, d8_err}, 8'd1);
    chk("miss_lock", {7'd0, d8_lk}, 8'd0);
    lit_frame("miss_hold", 4'b1100);
    beat(8'd1, 1'b1); beat(8'd0, 1'b0); beat(8'd0, 1'b0); beat(8'd1, 1'b0);
    lit_frame("relock_frame", 4'b1001);

    // Asynchronous reset mid-frame at slot 2.
    beat(8'd1, 1'b1); beat(8'd1, 1'b0);
    chk("pre_rst_slot", {6'd0, d8_slot}, 8'd2);
    #2;
    reset_n = 1'b0;
    #1;
    chk("arst_outs", d8_o0 | d8_o1 | d8_o2 | d8_o3, 8'd0);
    chk("arst_ctl", {4'd0, d8_fv, d8_err, d8_lk, d1_lk}, 8'd0);
    chk("arst_slot", {6'd0, d8_slot}, 8'd0);
    idle(1);
    reset_n = 1'b1;
    idle(1);
    beat(8'd0, 1'b1); beat(8'd1, 1'b0); beat(8'd0, 1'b0); beat(8'd1, 1'b0);
    lit_frame("post_rst_frame", 4'b1010);

    // Random frames with random gaps and occasional corrupted sync markers.
    for (int f = 0; f < 100; f++) begin
      for (int k = 0; k < 4; k++) begin
        d = 8'($urandom);
        s = (k == 0);
        if ($urandom_range(0, 15) == 0) s = ~s;
        beat(d, s);
        if ($urandom_range(0, 2) == 0) idle($urandom_range(0, 3));
      end
    end
    idle(3);

    chk_on = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
